bcd_number_entry: RTL and testbench
===================================

Name: bcd_number_entry

Overview:
- Input-side counterpart of the 7-segment display path: converts Basys3 button presses into a 13-bit binary operand.
- User edits four decimal digits with the buttons and commits them with the centre button.
- The block serially converts the BCD digits to binary and presents the result with a one-cycle valid strobe for the calculator core.
- The live digits and cursor position are exported so the display path can show the value being edited.

Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable synchronized samples needed to accept a new button level (2.5 ms at 100 MHz).
- REPEAT_CYCLES, 25000000, hold period between auto-repeat steps; used only with AUTO_REPEAT_EN.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- btnU  in  1  raw button: increment digit at cursor
- btnD  in  1  raw button: decrement digit at cursor
- btnL  in  1  raw button: move cursor left
- btnR  in  1  raw button: move cursor right
- btnC  in  1  raw button: commit/convert
- digits  out  16  live BCD digits; [15:12] is the leftmost digit
- cursor  out  2  selected digit; 3 = leftmost, 0 = rightmost
- busy  out  1  high while in CONVERT or DONE
- number  out  13  last committed binary value
- number_valid  out  1  one-cycle strobe when number updates
- overflow  out  1  sticky-until-next-commit; set if the entered value exceeded 8191

Behaviour:
- Reset (async, active-high) forces: digits=0, cursor=0, number=0, number_valid=0, overflow=0, busy=0, state=EDIT, all debounce counters and levels=0.
- Per-button conditioning:
  - 2-FF synchronizer feeds a counter.
  - The counter clears whenever the synchronized sample equals the debounced level.
  - When the sample has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
  - A rising edge of the debounced level gives a one-cycle press pulse.
- State EDIT handles at most one action per cycle, priority C > U > D > L > R; lower-priority pulses in the same cycle are dropped.
  - U: digit[cursor] +1, wraps 9->0.
  - D: digit[cursor] -1, wraps 0->9.
  - L: cursor +1, wraps 3->0.
  - R: cursor -1, wraps 0->3.
  - C: clear accumulator (14 bits), set index to 3, go to CONVERT.
- State CONVERT: exactly 4 cycles. Each cycle: acc <= acc*10 + digit[index], index decrements. After the index-0 cycle, go to DONE.
- State DONE: one cycle, then return to EDIT.
  - If acc > 8191: number <= 8191 (13'h1FFF), overflow <= 1.
  - Else: number <= acc[12:0], overflow <= 0.
  - number_valid = 1 for this single cycle.
- Latency: number_valid is high exactly 5 cycles after the cycle in which the C press pulse is high. number changes only in that same cycle.
- busy is high in CONVERT and DONE. Press pulses arriving during busy are discarded, not queued. Digits and cursor are frozen while busy.
- Digits are never reset by a commit; the user edits on from the committed value.
- Reset asserted mid-CONVERT aborts conversion: no number_valid, and all outputs take their reset values.
- A button held across reset release produces no press pulse until it is released and pressed again, because the debounced level and counter start at 0 and the level must first be seen changing.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: for U and D only, while the debounced level stays high, a repeat counter generates an extra press pulse every REPEAT_CYCLES after the initial edge. The counter clears on release, on reset, and while busy. Repeat pulses obey the same priority and busy-discard rules as normal presses.
- Not defined: exactly one action per physical press; the repeat counter logic is absent.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16):
- Bounce rejection: toggle btnU with 3-cycle glitches, then hold high 10 cycles -> digit[0] goes 0->1 exactly once; glitches alone give no change.
- Entry and commit: set digits to 1,2,3,4 (left to right) using L/R/U/D, press C -> number=1234 and number_valid high exactly 5 cycles after the C pulse; busy high for those 2 states (5 cycles total); overflow=0.
- Wrap-around: D on digit 0 -> 9; U on 9 -> 0; R at cursor 0 -> 3; L at cursor 3 -> 0.
- Saturation: enter 9999, commit -> number=8191, overflow=1. Then enter 8191, commit -> number=8191, overflow=0.
- Simultaneous and busy: btnC and btnU pulses in the same cycle -> conversion starts and digit is unchanged; btnU pressed during CONVERT -> ignored, digits unchanged after DONE.
- Reset mid-operation: assert Reset on the 2nd CONVERT cycle -> number=0, digits=0, no number_valid. With AUTO_REPEAT_EN, hold btnU 50 cycles after debounce -> digit increments 1+3=4 times.

Source files
------------

// File: rtl/bcd_number_entry.sv
// rtl/bcd_number_entry.sv - button-driven four-digit BCD entry with serial BCD-to-binary commit
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on the up/down buttons)
module bcd_number_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnC,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic        busy,
    output logic [12:0] number,
    output logic        number_valid,
    output logic        overflow
);
    localparam int NB  = 5;
    localparam int B_R = 0;
    localparam int B_L = 1;
    localparam int B_D = 2;
    localparam int B_U = 3;
    localparam int B_C = 4;
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {EDIT, CONVERT, DONE} state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] level;
    logic [NB-1:0] level_q;
    logic [NB-1:0] armed;
    logic [NB-1:0] edge_pulse;
    logic [NB-1:0] press;
    logic [DW-1:0] db_cnt [NB];
    logic [1:0]    fill;

    state_t        state;
    logic [13:0]   acc;
    logic [1:0]    index;
    logic [3:0]    cur_digit;
    logic [3:0]    conv_digit;
    logic [13:0]   acc_next;

    assign raw = {btnC, btnU, btnD, btnL, btnR};

    // Two-flop synchronizer; fill marks when sync2 carries real button samples after reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            fill  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
        end
    end

    // Debounce: adopt a new level only after it has differed for DEBOUNCE_CYCLES straight samples.
    // A button is armed once it has been seen released, so one held through reset stays silent.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NB; i++)
                db_cnt[i] <= '0;
            level   <= '0;
            level_q <= '0;
            armed   <= '0;
        end else begin
            level_q <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
                if (fill == 2'd2 && !sync2[i] && !level[i])
                    armed[i] <= 1'b1;
            end
        end
    end

    assign edge_pulse = level & ~level_q & armed;

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    ud_level;
    logic [1:0]    ud_level_q;
    logic [1:0]    ud_armed;
    logic [1:0]    rep_fire;

    assign ud_level   = {level[B_U], level[B_D]};
    assign ud_level_q = {level_q[B_U], level_q[B_D]};
    assign ud_armed   = {armed[B_U], armed[B_D]};

    // Hold-to-repeat timers for up/down; they restart after each release and stay idle while busy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!ud_level[j] || !ud_level_q[j] || busy)
                    rep_cnt[j] <= '0;
                else if (rep_cnt[j] == RP_LAST)
                    rep_cnt[j] <= '0;
                else
                    rep_cnt[j] <= rep_cnt[j] + RW'(1);
            end
        end
    end

    // A repeat step fires once the timer has run a full period with the button still held
    always_comb begin
        rep_fire = '0;
        for (int j = 0; j < 2; j++)
            rep_fire[j] = ud_level[j] && ud_level_q[j] && ud_armed[j] && !busy
                          && (rep_cnt[j] == RP_LAST);
    end

    assign press = edge_pulse | {1'b0, rep_fire[1], rep_fire[0], 2'b00};
`else
    assign press = edge_pulse;
`endif

    assign cur_digit  = digits[{cursor, 2'b00} +: 4];
    assign conv_digit = digits[{index, 2'b00} +: 4];
    assign acc_next   = acc * 14'd10 + {10'd0, conv_digit};

    // Edit/convert sequencer; the result registers on the last convert cycle so it shows in DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= EDIT;
            digits       <= '0;
            cursor       <= '0;
            busy         <= 1'b0;
            number       <= '0;
            number_valid <= 1'b0;
            overflow     <= 1'b0;
            acc          <= '0;
            index        <= '0;
        end else begin
            number_valid <= 1'b0;
            case (state)
                EDIT: begin
                    if (press[B_C]) begin
                        acc   <= '0;
                        index <= 2'd3;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else if (press[B_U]) begin
                        digits[{cursor, 2'b00} +: 4] <= (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
                    end else if (press[B_D]) begin
                        digits[{cursor, 2'b00} +: 4] <= (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                    end else if (press[B_L]) begin
                        cursor <= cursor + 2'd1;
                    end else if (press[B_R]) begin
                        cursor <= cursor - 2'd1;
                    end
                end
                CONVERT: begin
                    acc   <= acc_next;
                    index <= index - 2'd1;
                    if (index == 2'd0) begin
                        state        <= DONE;
                        number_valid <= 1'b1;
                        if (acc_next > 14'd8191) begin
                            number   <= 13'h1FFF;
                            overflow <= 1'b1;
                        end else begin
                            number   <= acc_next[12:0];
                            overflow <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= EDIT;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= EDIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_number_entry.sv
// tb/tb_bcd_number_entry.sv - scoreboard bench for bcd_number_entry
`timescale 1ns/1ps
module tb_bcd_number_entry;
    localparam int DEB = 4;
    localparam int REP = 16;
    // raw edge -> press pulse takes 2 sync + DEB debounce cycles, then 5 cycles to number_valid
    localparam int LAT = 2 + DEB + 5;

    localparam logic [4:0] M_R = 5'b00001;
    localparam logic [4:0] M_L = 5'b00010;
    localparam logic [4:0] M_D = 5'b00100;
    localparam logic [4:0] M_U = 5'b01000;
    localparam logic [4:0] M_C = 5'b10000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        btnU = 1'b0;
    logic        btnD = 1'b0;
    logic        btnL = 1'b0;
    logic        btnR = 1'b0;
    logic        btnC = 1'b0;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic        busy;
    logic [12:0] number;
    logic        number_valid;
    logic        overflow;

    bcd_number_entry #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .Clk(Clk), .Reset(Reset),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
        .digits(digits), .cursor(cursor), .busy(busy),
        .number(number), .number_valid(number_valid), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int num;
        int ovf;
        int due;
    } exp_t;
    exp_t sbq[$];

    int md[4];
    int mcur;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result
    int busy_run = 0;
    int prev_number = 0;
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset) begin
            busy_run = 0;
            prev_number = 0;
        end else begin
            busy_run = busy ? busy_run + 1 : 0;
            if (number_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("number", int'(number), e.num);
                    check("overflow", int'(overflow), e.ovf);
                    check("valid_latency", cyc, e.due);
                    check("busy_cycles", busy_run, 5);
                end
            end else if (int'(number) != prev_number) begin
                check("number_changed_without_valid", int'(number), prev_number);
            end
            prev_number = int'(number);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive(input logic [4:0] m);
        {btnC, btnU, btnD, btnL, btnR} = m;
    endtask

    task automatic model_apply(input logic [4:0] m, input int t0);
        exp_t e;
        int v;
        if (m[4]) begin
            v = md[3] * 1000 + md[2] * 100 + md[1] * 10 + md[0];
            e.num = (v > 8191) ? 8191 : v;
            e.ovf = (v > 8191) ? 1 : 0;
            e.due = t0 + LAT;
            sbq.push_back(e);
        end else if (m[3]) md[mcur] = (md[mcur] + 1) % 10;
        else if (m[2]) md[mcur] = (md[mcur] + 9) % 10;
        else if (m[1]) mcur = (mcur + 1) % 4;
        else if (m[0]) mcur = (mcur + 3) % 4;
    endtask

    task automatic check_state(input string tag);
        int ed;
        ed = md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0];
        check({tag, "_digits"}, int'(digits), ed);
        check({tag, "_cursor"}, int'(cursor), mcur);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic press(input logic [4:0] m);
        int t0;
        @(negedge Clk);
        t0 = cyc;
        model_apply(m, t0);
        drive(m);
        cycles(10);
        drive(5'b0);
        cycles(10);
        check_state("press");
    endtask

    task automatic enter_value(input int v);
        int t[4];
        t[0] = v % 10;
        t[1] = (v / 10) % 10;
        t[2] = (v / 100) % 10;
        t[3] = (v / 1000) % 10;
        for (int p = 0; p < 4; p++) begin
            while (mcur != p) press(M_L);
            while (md[p] != t[p]) press((((t[p] - md[p] + 10) % 10) <= 5) ? M_U : M_D);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, int'(digits), 0);
        check({tag, "_cursor"}, int'(cursor), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_number"}, int'(number), 0);
        check({tag, "_valid"}, int'(number_valid), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        int r;
        for (int i = 0; i < 4; i++) md[i] = 0;
        mcur = 0;

        cycles(3);
        check_reset_outputs("reset");
        Reset = 1'b0;
        cycles(5);
        check_reset_outputs("post_reset");

        // Bounce rejection: three short glitches change nothing, a solid press counts once
        repeat (3) begin
            drive(M_U);
            cycles(3);
            drive(5'b0);
            cycles(3);
        end
        cycles(10);
        check_state("glitch_only");
        press(M_U);
        check("bounce_digit0", int'(digits[3:0]), 1);

        // Entry and commit of 1234
        enter_value(1234);
        check("entry_digits", int'(digits), 16'h1234);
        press(M_C);

        // Wrap-around on digit 0 and on the cursor
        while (mcur != 0) press(M_R);
        while (md[0] != 0) press(M_D);
        press(M_D);
        check("wrap_dec", int'(digits[3:0]), 9);
        press(M_U);
        check("wrap_inc", int'(digits[3:0]), 0);
        press(M_R);
        check("wrap_right", int'(cursor), 3);
        press(M_L);
        check("wrap_left", int'(cursor), 0);

        // Saturation and the boundary values either side of it
        enter_value(9999);
        press(M_C);
        enter_value(8191);
        press(M_C);
        enter_value(8192);
        press(M_C);
        enter_value(0);
        press(M_C);

        // Simultaneous C and U: commit wins, digit untouched
        press(M_C | M_U);

        // U pressed during conversion is discarded
        @(negedge Clk);
        t0 = cyc;
        model_apply(M_C, t0);
        drive(M_C);
        cycles(2);
        drive(M_C | M_U);
        cycles(8);
        drive(5'b0);
        cycles(14);
        check_state("busy_discard");

        // Randomized editing and commits
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: press(M_U);
                2, 3: press(M_D);
                4, 5: press(M_L);
                6, 7: press(M_R);
                8:    press(M_C);
                default: press(M_C | 5'(1 << $urandom_range(0, 3)));
            endcase
        end

        // Reset on the second convert cycle aborts; C held across release gives no commit
        cycles(5);
        @(negedge Clk);
        t0 = cyc;
        drive(M_C);
        cycles(LAT - 3);
        check("busy_before_abort", int'(busy), 1);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) md[i] = 0;
        mcur = 0;
        cycles(3);
        check_reset_outputs("abort");
        Reset = 1'b0;
        cycles(20);
        drive(5'b0);
        cycles(20);
        check_reset_outputs("held_across_reset");
        press(M_U);

`ifdef AUTO_REPEAT_EN
        // Held U: initial step plus one per REP cycles while held
        @(negedge Clk);
        drive(M_U);
        cycles(2 + DEB + 50);
        drive(5'b0);
        cycles(30);
        md[mcur] = (md[mcur] + 4) % 10;
        check_state("auto_repeat");
`endif

        cycles(20);
        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
